// File: rtl/rob_ctrl_if.sv
// Bundle between the dispatch/execute side and the reorder-buffer controller.
// The bundle also carries the ROB storage RAM write/read port controls that the
// controller drives.
//   master : issues allocations, completions and flushes; observes tags, RAM port
//            controls, commits and occupancy.
//   slave  : the rob_ctrl block itself.
interface rob_ctrl_if #(
  parameter int unsigned ADDR = 4
);
  // Allocation (dispatch side)
  logic            alloc_req_0;
  logic            alloc_req_1;
  logic            alloc_ready;
  logic [ADDR-1:0] alloc_tag_0;
  logic [ADDR-1:0] alloc_tag_1;
  // RAM write ports
  logic            wr_en_0;
  logic            wr_en_1;
  logic [ADDR-1:0] addr_in_0;
  logic [ADDR-1:0] addr_in_1;
  // Completion (execute side)
  logic            cmpl_valid;
  logic [ADDR-1:0] cmpl_tag;
  // RAM read ports 0/1 (head, head+1)
  logic            o_en_0;
  logic            o_en_1;
  logic [ADDR-1:0] addr_out_0;
  logic [ADDR-1:0] addr_out_1;
  // Retirement
  logic            commit_valid_0;
  logic            commit_valid_1;
  logic [ADDR-1:0] commit_tag_0;
  logic [ADDR-1:0] commit_tag_1;
  // Squash and occupancy
  logic            flush;
  logic [ADDR:0]   count;
  logic            full;
  logic            empty;

  modport master (
    output alloc_req_0, alloc_req_1, cmpl_valid, cmpl_tag, flush,
    input  alloc_ready, alloc_tag_0, alloc_tag_1,
    input  wr_en_0, wr_en_1, addr_in_0, addr_in_1,
    input  o_en_0, o_en_1, addr_out_0, addr_out_1,
    input  commit_valid_0, commit_valid_1, commit_tag_0, commit_tag_1,
    input  count, full, empty
  );

  modport slave (
    input  alloc_req_0, alloc_req_1, cmpl_valid, cmpl_tag, flush,
    output alloc_ready, alloc_tag_0, alloc_tag_1,
    output wr_en_0, wr_en_1, addr_in_0, addr_in_1,
    output o_en_0, o_en_1, addr_out_0, addr_out_1,
    output commit_valid_0, commit_valid_1, commit_tag_0, commit_tag_1,
    output count, full, empty
  );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller sitting in front of the ROB storage RAM.
// Allocates up to two in-order entries per cycle at the tail, marks entries done
// on completion by tag, and retires up to two done entries per cycle from the head.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-low reset
//   bus   : rob_ctrl_if.slave -- alloc/completion/flush inputs, RAM write and
//           read port controls, commit outputs and occupancy status
module rob_ctrl #(
  parameter int unsigned ADDR  = 4,
  parameter int unsigned DEPTH = 1 << ADDR
) (
  input logic       clk,
  input logic       reset,
  rob_ctrl_if.slave bus
);

  localparam logic [ADDR:0] DepthCnt = (ADDR+1)'(DEPTH);

  logic [ADDR-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ADDR-1:0]  head1, tail1;
  logic [ADDR:0]    count_q, count_d, free_cnt;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic             alloc_ready, acc0, acc1, cv0, cv1;

  // Output-side decode, all from registered state plus this cycle's requests.
  always_comb begin
    free_cnt    = DepthCnt - count_q;
    // Same-cycle commits never free space for allocation; this margin is what
    // keeps a new tail from landing on an entry that is retiring this cycle.
    alloc_ready = free_cnt >= (ADDR+1)'(2);
    tail1       = tail_q + ADDR'(1);
    head1       = head_q + ADDR'(1);
    acc0        = alloc_ready & bus.alloc_req_0 & ~bus.flush;
    acc1        = acc0 & bus.alloc_req_1;
    cv0         = valid_q[head_q] & done_q[head_q] & ~bus.flush;
    cv1         = cv0 & valid_q[head1] & done_q[head1];
  end

  assign bus.alloc_ready    = alloc_ready;
  assign bus.alloc_tag_0    = tail_q;
  assign bus.alloc_tag_1    = tail1;
  assign bus.wr_en_0        = acc0;
  assign bus.wr_en_1        = acc1;
  assign bus.addr_in_0      = tail_q;
  assign bus.addr_in_1      = tail1;
  assign bus.o_en_0         = valid_q[head_q];
  assign bus.o_en_1         = valid_q[head1];
  assign bus.addr_out_0     = head_q;
  assign bus.addr_out_1     = head1;
  assign bus.commit_valid_0 = cv0;
  assign bus.commit_valid_1 = cv1;
  assign bus.commit_tag_0   = head_q;
  assign bus.commit_tag_1   = head1;
  assign bus.count          = count_q;
  assign bus.full           = (count_q == DepthCnt);
  assign bus.empty          = (count_q == '0);

  // Next-state. Completion is applied before retirement so a completion hitting
  // an entry that retires this cycle leaves no stale done bit behind.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (bus.cmpl_valid && valid_q[bus.cmpl_tag]) begin
        done_d[bus.cmpl_tag] = 1'b1;
      end
      if (cv0) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
      end
      if (cv1) begin
        valid_d[head1] = 1'b0;
        done_d[head1]  = 1'b0;
      end
      if (acc0) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
      end
      if (acc1) begin
        valid_d[tail1] = 1'b1;
        done_d[tail1]  = 1'b0;
      end
      head_d  = head_q + ADDR'(cv0) + ADDR'(cv1);
      tail_d  = tail_q + ADDR'(acc0) + ADDR'(acc1);
      count_d = count_q + (ADDR+1)'(acc0) + (ADDR+1)'(acc1)
                        - (ADDR+1)'(cv0) - (ADDR+1)'(cv1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
- Reorder-buffer controller that sits directly in front of the ROB storage RAM (2 write ports, 3 read ports) and drives its write and read ports.
- Allocates up to 2 in-order entries per cycle at the tail and tracks a per-entry valid and done bit.
- Accepts one completion per cycle by tag.
- Retires up to 2 completed entries per cycle in order from the head, presenting head addresses on RAM read ports 0/1.
- Read port 2 (operand lookup) is outside this block.

Parameters:
- ADDR, 4, tag/index width.
- DEPTH, 1<<ADDR, number of ROB entries (power of two only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- alloc_req_0  in  1  request one entry (oldest dispatch slot).
- alloc_req_1  in  1  request a second entry; ignored unless alloc_req_0=1.
- alloc_ready  out  1  at least 2 free entries this cycle.
- alloc_tag_0  out  ADDR  tag for slot 0 (= tail).
- alloc_tag_1  out  ADDR  tag for slot 1 (= tail+1 mod DEPTH).
- wr_en_0, wr_en_1  out  1 each  RAM write enables.
- addr_in_0, addr_in_1  out  ADDR each  RAM write addresses.
- cmpl_valid  in  1  execution result done.
- cmpl_tag  in  ADDR  tag of the completed entry.
- o_en_0, o_en_1  out  1 each  RAM read enables for head and head+1.
- addr_out_0, addr_out_1  out  ADDR each  head and head+1 addresses.
- commit_valid_0, commit_valid_1  out  1 each  entry retires this cycle.
- commit_tag_0, commit_tag_1  out  ADDR each  retiring tags.
- flush  in  1  synchronous squash of all entries.
- count  out  ADDR+1  occupied entries, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- State:
  - head, tail: ADDR bits, wrap mod DEPTH.
  - count: ADDR+1 bits.
  - valid[DEPTH], done[DEPTH].
- Reset (async, reset=0): head=tail=0, count=0, all valid/done=0. Hence alloc_ready=1, empty=1, full=0, commit_valid_*=0, wr_en_*=0.
- Allocation:
  - alloc_ready = (DEPTH-count)>=2, from the registered count only; same-cycle commits do not free space.
  - Accepted slot k when alloc_ready & alloc_req_k (& alloc_req_0 for k=1).
  - wr_en_k = accepted_k; addr_in_k = alloc_tag_k; combinational in the same cycle.
  - At the edge: valid[tag]=1, done[tag]=0, tail += nalloc (0/1/2).
- Completion:
  - If cmpl_valid & valid[cmpl_tag]: done[cmpl_tag]=1 at the edge.
  - Completion to an invalid entry is ignored.
  - Done is registered, so it is not visible to commit until the next cycle.
- Commit (combinational from registered state):
  - o_en_0 = valid[head]; addr_out_0 = head.
  - o_en_1 = valid[head+1]; addr_out_1 = head+1.
  - commit_valid_0 = valid[head] & done[head].
  - commit_valid_1 = commit_valid_0 & valid[head+1] & done[head+1].
  - commit_tag_k = addr_out_k.
  - At the edge: retired entries get valid=0, done=0; head += ncommit.
- Simultaneous events:
  - count_next = count + nalloc - ncommit.
  - An allocation to an index being retired in the same cycle cannot occur, because the alloc_ready margin guarantees it.
  - A completion to an index being retired is harmless.
- Flush:
  - At the edge: head=tail=0, count=0, all valid/done=0.
  - Flush takes priority over alloc/cmpl/commit in the same cycle.
  - While flush=1: wr_en_*=0 and commit_valid_*=0.
- Wrap-around: tail and head roll from DEPTH-1 to 0; tag DEPTH-1 is followed by tag 0 in a dual allocation.
- Reset mid-operation clears everything asynchronously; outputs return to reset values without waiting for clk.

Test Plan:
- Reset, then alloc_req_0=alloc_req_1=1 for 1 cycle -> alloc_tag 0/1, wr_en_0/1=1, addr_in 0/1; next cycle count=2, tail=2, empty=0.
- Allocate 4, complete tags 1 then 0 in consecutive cycles -> no commit while only tag 1 is done; the cycle after tag 0 is done, commit_valid_0/1=1 with tags 0/1, then count=2.
- Allocate 14 (count=14) -> alloc_ready=1; allocate 2 more -> count=16, full=1, alloc_ready=0, further requests produce wr_en=0.
- Fill with tags 14,15,0,1 after head=14, complete all -> commits 14/15, then 0/1 the next cycle; head wraps to 2.
- count=15 with head done and alloc_req_0=1 in the same cycle -> alloc_ready=0, one commit, count=14.
- flush asserted alongside alloc_req_0 and cmpl_valid -> no wr_en, no commit; next cycle count=0, head=tail=0. Then async reset=0 mid-burst -> empty=1 immediately.
